// File: rtl/ghash_pkg.sv
// ghash_pkg: shared types, constants and GF(2^128) helpers for the GHASH engine.
package ghash_pkg;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIN_MUL} state_e;
    // GCM reduction constant: x^128 = 1 + x + x^2 + x^7 in the reflected bit order.
    localparam logic [127:0] GF128_R = {8'he1, 120'h0};
    typedef struct packed {
        logic [127:0] z;
        logic [127:0] v;
    } gf128_zv_t;
    function automatic int mul_cycles(input int digit_w);
        return 128 / digit_w;
    endfunction
    function automatic int cnt_width(input int digit_w);
        return $clog2(128 / digit_w + 1);
    endfunction
    // Zero every byte at index >= nbytes; byte 0 sits in bits [127:120].
    function automatic logic [127:0] gf128_mask_bytes(input logic [127:0] data, input logic [4:0] nbytes);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[127 - 8 * i -: 8] = (5'(i) < nbytes) ? data[127 - 8 * i -: 8] : 8'h00;
        return r;
    endfunction
    // Consume the top digit_w bits of digit, MSB first: conditionally fold V into Z, then V *= x.
    function automatic gf128_zv_t gf128_digit_step(input logic [127:0] z, input logic [127:0] v,
                                                   input logic [127:0] digit, input int digit_w);
        gf128_zv_t r;
        r.z = z;
        r.v = v;
        for (int i = 0; i < 128; i++) begin
            if (i < digit_w) begin
                if (digit[127 - i]) r.z = r.z ^ r.v;
                r.v = r.v[0] ? ((r.v >> 1) ^ GF128_R) : (r.v >> 1);
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/ghash_stream_if.sv
// ghash_stream_if: block/finalize/tag bus of the GHASH engine.
//   master drives key load, blocks and finalize; slave returns ready, tag, tag_valid, err.
interface ghash_stream_if;
    logic         h_load;
    logic [127:0] H;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_data;
    logic [4:0]   blk_bytes;
    logic         blk_is_ad;
    logic         fin_valid;
    logic [127:0] tag;
    logic         tag_valid;
    logic         err;
    modport master (output h_load, H, blk_valid, blk_data, blk_bytes, blk_is_ad, fin_valid,
                    input blk_ready, tag, tag_valid, err);
    modport slave (input h_load, H, blk_valid, blk_data, blk_bytes, blk_is_ad, fin_valid,
                   output blk_ready, tag, tag_valid, err);
endinterface

// File: rtl/gf128_mul_digit.sv
// gf128_mul_digit: digit-serial GF(2^128) multiplier, DIGIT_W operand bits per cycle.
//   start/a/b: launch a*b when idle; done: high in the last step cycle; z: product valid with done.
module gf128_mul_digit
    import ghash_pkg::*;
#(
    parameter int DIGIT_W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] a,
    input  logic [127:0] b,
    output logic         done,
    output logic [127:0] z
);
    localparam int N  = mul_cycles(DIGIT_W);
    localparam int CW = cnt_width(DIGIT_W);

    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [127:0]  x_q, x_d, v_q, v_d, z_q, z_d;
    gf128_zv_t     step;

    // The product is taken straight from the final step so the caller sees it without an extra cycle.
    always_comb begin
        step   = gf128_digit_step(z_q, v_q, x_q, DIGIT_W);
        done   = busy_q && cnt_q == CW'(1);
        z      = step.z;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        x_d    = x_q;
        v_d    = v_q;
        z_d    = z_q;
        if (busy_q) begin
            busy_d = !done;
            cnt_d  = cnt_q - CW'(1);
            x_d    = x_q << DIGIT_W;
            v_d    = step.v;
            z_d    = step.z;
        end else if (start) begin
            busy_d = 1'b1;
            cnt_d  = CW'(N);
            x_d    = a;
            v_d    = b;
            z_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            x_q    <= '0;
            v_q    <= '0;
            z_q    <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            x_q    <= x_d;
            v_q    <= v_d;
            z_q    <= z_d;
        end
    end
endmodule

// File: rtl/ghash_stream.sv
// ghash_stream: streaming GHASH engine with byte masking, length tracking and finalize.
//   clk, reset_n (async, active-low); bus (slave): h_load/H key load, blk_* block handshake,
//   fin_valid finalize request, tag/tag_valid result, err sticky protocol error.
module ghash_stream
    import ghash_pkg::*;
#(
    parameter int DIGIT_W = 8
) (
    input logic           clk,
    input logic           reset_n,
    ghash_stream_if.slave bus
);
    state_e       state_q, state_d;
    logic         ready_q, ready_d;
    logic [127:0] h_q, h_d, x_q, x_d, tag_q, tag_d;
    logic [63:0]  len_ad_q, len_ad_d, len_i_q, len_i_d;
    logic         seen_i_q, seen_i_d, err_q, err_d, tag_valid_q, tag_valid_d;
    logic         idle, blk_ok, take_blk, take_fin, mul_start, mul_done;
    logic [127:0] mul_a, mul_z;
    logic [63:0]  blk_bits;

    // ready_q doubles as the idle qualifier so nothing is accepted before the first clock after reset.
    always_comb begin
        idle        = state_q == S_IDLE && ready_q;
        blk_ok      = bus.blk_bytes != 5'd0 && bus.blk_bytes <= 5'd16 && !(bus.blk_is_ad && seen_i_q);
        blk_bits    = {56'h0, bus.blk_bytes, 3'b000};
        take_blk    = idle && !bus.h_load && bus.blk_valid;
        take_fin    = idle && !bus.h_load && !bus.blk_valid && bus.fin_valid;
        mul_start   = (take_blk && blk_ok) || take_fin;
        mul_a       = take_blk ? x_q ^ gf128_mask_bytes(bus.blk_data, bus.blk_bytes)
                               : x_q ^ {len_ad_q, len_i_q};
        state_d     = state_q;
        h_d         = h_q;
        x_d         = x_q;
        tag_d       = tag_q;
        len_ad_d    = len_ad_q;
        len_i_d     = len_i_q;
        seen_i_d    = seen_i_q;
        err_d       = err_q;
        tag_valid_d = 1'b0;
        if (idle && bus.h_load) begin
            h_d      = bus.H;
            x_d      = '0;
            len_ad_d = '0;
            len_i_d  = '0;
            seen_i_d = 1'b0;
            err_d    = 1'b0;
        end else if (take_blk && !blk_ok) begin
            err_d = 1'b1;
        end else if (take_blk) begin
            state_d  = S_MUL;
            len_ad_d = bus.blk_is_ad ? len_ad_q + blk_bits : len_ad_q;
            len_i_d  = bus.blk_is_ad ? len_i_q : len_i_q + blk_bits;
            seen_i_d = seen_i_q || !bus.blk_is_ad;
        end else if (take_fin) begin
            state_d = S_FIN_MUL;
        end else if (mul_done) begin
            state_d = S_IDLE;
            if (state_q == S_FIN_MUL) begin
                tag_d       = mul_z;
                tag_valid_d = 1'b1;
                x_d         = '0;
                len_ad_d    = '0;
                len_i_d     = '0;
                seen_i_d    = 1'b0;
            end else begin
                x_d = mul_z;
            end
        end
        ready_d = state_d == S_IDLE;
    end

    gf128_mul_digit #(.DIGIT_W(DIGIT_W)) u_mul (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (mul_start),
        .a      (mul_a),
        .b      (h_q),
        .done   (mul_done),
        .z      (mul_z)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            h_q         <= '0;
            x_q         <= '0;
            tag_q       <= '0;
            len_ad_q    <= '0;
            len_i_q     <= '0;
            seen_i_q    <= 1'b0;
            err_q       <= 1'b0;
            tag_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            h_q         <= h_d;
            x_q         <= x_d;
            tag_q       <= tag_d;
            len_ad_q    <= len_ad_d;
            len_i_q     <= len_i_d;
            seen_i_q    <= seen_i_d;
            err_q       <= err_d;
            tag_valid_q <= tag_valid_d;
        end
    end

    // A key load takes the cycle, so the engine does not advertise ready alongside it.
    assign bus.blk_ready = ready_q && !bus.h_load;
    assign bus.tag       = tag_q;
    assign bus.tag_valid = tag_valid_q;
    assign bus.err       = err_q;
endmodule
